// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
//   sw_state_t          run/pause state encoding
//   ONES_MAX, TENS_MAX  last value of each seconds digit before it rolls over
//   AN_ONES, AN_TENS    active-low anode patterns for each selected digit
package stopwatch_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } sw_state_t;

    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [2:0] TENS_MAX = 3'd5;

    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;

endpackage

// File: rtl/stopwatch_core_if.sv
// Bundle of button inputs and display-side outputs of the stopwatch core.
//   start_stop  raw button, each rising edge toggles run/pause
//   clear       raw button, level-sensitive zeroing of the count
//   ones, tens  seconds digits (0-9, 0-5)
//   enable      decoder digit select: 1 = ones, 0 = tens
//   an          active-low anodes, in step with enable
//   running     high while counting
//   wrap        one-cycle pulse on the 59 -> 00 rollover
// master: the side that presses buttons and watches the display.
// slave:  the stopwatch core.
interface stopwatch_core_if;

    logic       start_stop;
    logic       clear;
    logic [3:0] ones;
    logic [2:0] tens;
    logic       enable;
    logic [1:0] an;
    logic       running;
    logic       wrap;

    modport master (
        output start_stop, clear,
        input  ones, tens, enable, an, running, wrap
    );

    modport slave (
        input  start_stop, clear,
        output ones, tens, enable, an, running, wrap
    );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous button, plus a rising-edge
// detector on the synchronised level.
//   clk      system clock
//   reset    synchronous, active-high; clears all three flops
//   d_async  raw asynchronous input
//   level    synchronised level (second synchroniser flop)
//   rise     one-cycle pulse when level goes 0 -> 1
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d_async,
    output logic level,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    // NOTE: non-blocking assignments so every flop samples the value from
    // before this edge; blocking ones would collapse the chain into one stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= d_async;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign level = sync2;
    assign rise  = sync2 & ~prev;

endmodule

// File: rtl/stopwatch_core.sv
// Seconds counter (00-59) with run/pause control, clear, and a 2-digit
// multiplexed display refresh for a 7-segment decoder.
//   clk    system clock, all logic on the rising edge
//   reset  synchronous, active-high; overrides every other input
//   bus    stopwatch_core_if.slave: buttons in, digits/anodes/status out
// Parameters:
//   TICK_DIV     clock cycles per one-second count tick (>= 2)
//   REFRESH_DIV  clock cycles per display digit toggle (>= 1)
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV    = 100_000_000,
    parameter int REFRESH_DIV = 100_000
) (
    input  logic             clk,
    input  logic             reset,
    stopwatch_core_if.slave  bus
);

    localparam int              PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX   = PW'(TICK_DIV - 1);
    localparam int              RW          = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0]   REFRESH_MAX = RW'(REFRESH_DIV - 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic start_rise;
    logic clear_level;
    logic unused_start_level;
    logic unused_clear_rise;

    sync_edge u_sync_start (
        .clk     (clk),
        .reset   (reset),
        .d_async (bus.start_stop),
        .level   (unused_start_level),
        .rise    (start_rise)
    );

    sync_edge u_sync_clear (
        .clk     (clk),
        .reset   (reset),
        .d_async (bus.clear),
        .level   (clear_level),
        .rise    (unused_clear_rise)
    );

    // ------------------------------------------------------------------
    // Run/pause FSM
    // ------------------------------------------------------------------
    sw_state_t state;
    sw_state_t state_next;
    logic      running;

    always_ff @(posedge clk) begin
        if (reset) state <= STOPPED;
        else       state <= state_next;
    end

    // NOTE: state_next gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        if (start_rise) begin
            case (state)
                STOPPED: state_next = RUNNING;
                RUNNING: state_next = STOPPED;
                default: state_next = STOPPED;
            endcase
        end
    end

    always_comb begin
        running = (state == RUNNING);
    end

    // ------------------------------------------------------------------
    // Prescaler and seconds count
    // ------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic          tick;
    logic [3:0]    ones_q;
    logic [2:0]    tens_q;
    logic          wrap_q;

    assign tick = running && (presc == PRESC_MAX);

    // clear wins over a coincident tick; the FSM is untouched by clear, so
    // a clear while running resumes counting from 00.
    always_ff @(posedge clk) begin
        if (reset || clear_level) begin
            presc  <= '0;
            ones_q <= '0;
            tens_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            // Prescaler holds while stopped so a pause keeps the partial second.
            if (running) begin
                presc <= tick ? '0 : presc + 1'b1;
            end
            if (tick) begin
                if (ones_q == ONES_MAX) begin
                    ones_q <= '0;
                    if (tens_q == TENS_MAX) begin
                        tens_q <= '0;
                        wrap_q <= 1'b1;
                    end else begin
                        tens_q <= tens_q + 1'b1;
                    end
                end else begin
                    ones_q <= ones_q + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Display refresh: free-running, independent of FSM and clear
    // ------------------------------------------------------------------
    logic [RW-1:0] refresh_cnt;
    logic          enable_q;
    logic [1:0]    an_q;

    // an is registered alongside enable from the same decision, so the two
    // can never disagree and an is always exactly one-hot-low.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            enable_q    <= 1'b1;
            an_q        <= AN_ONES;
        end else if (refresh_cnt == REFRESH_MAX) begin
            refresh_cnt <= '0;
            enable_q    <= ~enable_q;
            an_q        <= enable_q ? AN_TENS : AN_ONES;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ones    = ones_q;
    assign bus.tens    = tens_q;
    assign bus.enable  = enable_q;
    assign bus.an      = an_q;
    assign bus.running = running;
    assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core with TICK_DIV=4, REFRESH_DIV=2.
// A behavioural model tracks elapsed seconds as a single integer, the
// button pipeline as a history of raw samples, and the display phase as a
// function of cycles since reset; every cycle all outputs are compared.
module tb_stopwatch_core;

    localparam int TICK_DIV    = 4;
    localparam int REFRESH_DIV = 2;

    logic clk = 1'b0;
    logic reset;

    stopwatch_core_if bus ();

    stopwatch_core #(
        .TICK_DIV    (TICK_DIV),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int m_secs  = 0;   // elapsed seconds, 0..59
    int m_presc = 0;   // clocks into the current second
    int m_n     = 0;   // clock edges since reset released
    bit m_run   = 0;
    bit m_wrap  = 0;
    bit ss_hist [1:3]; // raw start_stop sampled 1, 2, 3 edges ago
    bit cl_hist [1:3];
    bit m_rise, m_clr, m_tick;

    always @(posedge clk) begin
        if (reset) begin
            m_secs = 0; m_presc = 0; m_n = 0; m_run = 0; m_wrap = 0;
            for (int i = 1; i <= 3; i++) begin
                ss_hist[i] = 0;
                cl_hist[i] = 0;
            end
        end else begin
            // A button seen 2 edges ago acts now; a rise needs it low 3 edges ago.
            m_rise = ss_hist[2] && !ss_hist[3];
            m_clr  = cl_hist[2];
            m_tick = m_run && (m_presc == TICK_DIV - 1);
            m_wrap = 0;
            if (m_clr) begin
                m_secs  = 0;
                m_presc = 0;
            end else if (m_run) begin
                if (m_tick) begin
                    m_presc = 0;
                    m_secs  = (m_secs + 1) % 60;
                    m_wrap  = (m_secs == 0);
                end else begin
                    m_presc++;
                end
            end
            if (m_rise) m_run = !m_run;
            m_n++;
            ss_hist[3] = ss_hist[2]; ss_hist[2] = ss_hist[1]; ss_hist[1] = bus.start_stop;
            cl_hist[3] = cl_hist[2]; cl_hist[2] = cl_hist[1]; cl_hist[1] = bus.clear;
        end
    end

    task automatic compare_all();
        bit en;
        en = ((m_n / REFRESH_DIV) % 2) == 0;
        check("ones",    bus.ones,    m_secs % 10);
        check("tens",    bus.tens,    m_secs / 10);
        check("enable",  bus.enable,  en);
        check("an",      bus.an,      en ? 2 : 1);
        check("running", bus.running, m_run);
        check("wrap",    bus.wrap,    m_wrap);
    endtask

    // Drive inputs, take one clock edge, then compare just after it.
    task automatic cycle(input bit ss, input bit cl, input bit rst);
        bus.start_stop = ss;
        bus.clear      = cl;
        reset          = rst;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0);
    endtask

    task automatic run_until(input int target, input int budget);
        int k;
        k = 0;
        while (m_secs != target && k < budget) begin
            cycle(0, 0, 0);
            k++;
        end
        if (m_secs != target) check("run_until_timeout", 0, 1);
    endtask

    initial begin
        int k;
        bus.start_stop = 0;
        bus.clear      = 0;
        reset          = 1;

        // 1. Reset
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        check("rst_ones",    bus.ones,    0);
        check("rst_tens",    bus.tens,    0);
        check("rst_running", bus.running, 0);
        check("rst_wrap",    bus.wrap,    0);
        check("rst_enable",  bus.enable,  1);
        check("rst_an",      bus.an,      2'b10);
        idle(6);

        // 2. Start: running appears on the 3rd edge after the pulse is sampled
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        check("start_pre", bus.running, 0);
        cycle(0, 0, 0);
        check("start_lat", bus.running, 1);
        run_until(10, 60);
        check("ten_ones", bus.ones, 0);
        check("ten_tens", bus.tens, 1);

        // 3. Rollover 59 -> 00
        run_until(59, 300);
        k = 0;
        while (bus.wrap !== 1'b1 && k < 8) begin
            cycle(0, 0, 0);
            k++;
        end
        check("wrap_seen", bus.wrap, 1);
        check("wrap_ones", bus.ones, 0);
        check("wrap_tens", bus.tens, 0);
        cycle(0, 0, 0);
        check("wrap_pulse_len", bus.wrap, 0);
        run_until(3, 40);

        // 4. Pause 2 cycles after a tick, hold, resume
        run_until((m_secs + 1) % 60, 10);
        idle(2);
        cycle(1, 0, 0);
        idle(22);
        check("paused", bus.running, 0);
        cycle(1, 0, 0);
        idle(14);

        // 5. Clear at 37 while running
        run_until(37, 300);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        check("clr_running", bus.running, 1);
        check("clr_ones",    bus.ones,    0);
        check("clr_tens",    bus.tens,    0);
        idle(12);

        // 6A. Clear and start_stop together while stopped at 12
        run_until(12, 300);
        cycle(1, 0, 0);
        idle(5);
        check("stop12_running", bus.running, 0);
        check("stop12_ones",    bus.ones,    2);
        check("stop12_tens",    bus.tens,    1);
        cycle(1, 1, 0);
        idle(2);
        check("both_running", bus.running, 1);
        check("both_ones",    bus.ones,    0);
        check("both_tens",    bus.tens,    0);
        idle(6);

        // 6B. Reset mid-run at 45
        run_until(45, 300);
        cycle(0, 0, 1);
        check("midrst_ones",    bus.ones,    0);
        check("midrst_tens",    bus.tens,    0);
        check("midrst_running", bus.running, 0);
        check("midrst_enable",  bus.enable,  1);
        check("midrst_an",      bus.an,      2'b10);
        idle(4);

        // Randomized traffic against the model
        cycle(1, 0, 0);
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 15) == 0,
                  $urandom_range(0, 40) == 0,
                  $urandom_range(0, 250) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Timekeeping source for the stopwatch's 2-digit 7-segment display: counts seconds 00–59 and drives the segment decoder's inputs.
- Outputs ones (4-bit BCD 0–9), tens (3-bit 0–5) and enable (1 = ones digit selected, 0 = tens digit selected).
- Generates active-low anode selects in step with enable.
- Owns the start/stop and clear button handling and the run/pause state machine.

Parameters:
- TICK_DIV, 100_000_000, clock cycles per one-second count tick (minimum 2).
- REFRESH_DIV, 100_000, clock cycles per display digit toggle (minimum 1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start_stop  input  1  raw asynchronous button; each rising edge toggles run/pause.
- clear  input  1  raw asynchronous button; while its synchronised level is high, counts and prescaler are zeroed.
- ones  output  4  seconds ones digit, 0–9.
- tens  output  3  seconds tens digit, 0–5.
- enable  output  1  digit select to decoder: 1 = ones, 0 = tens.
- an  output  2  anodes, active low: 2'b10 when enable=1 (ones on an[0]), 2'b01 when enable=0.
- running  output  1  high in RUNNING state.
- wrap  output  1  one-cycle pulse when the count rolls 59 -> 00.

Behaviour:
- Reset (synchronous, active-high; all registers clear on a clk edge while reset=1):
  - ones=0, tens=0, running=0, wrap=0.
  - enable=1, an=2'b10.
  - Prescaler, refresh counter and synchroniser flops all 0.
  - reset takes priority over every other input, including mid-count and mid-toggle.
- Input conditioning (start_stop and clear):
  - Each passes through a 2-flop synchroniser.
  - start_stop additionally has a previous-value flop; edge = sync2 & ~prev.
  - No debounce in this block; the button board is clean.
  - Latency: running changes on the 3rd rising clk edge after start_stop is first sampled high.
  - clear takes effect on the 3rd edge after it is first sampled high.
- FSM, states STOPPED and RUNNING:
  - STOPPED -> RUNNING on edge.
  - RUNNING -> STOPPED on edge.
  - running = (state == RUNNING).
- Prescaler, 0..TICK_DIV-1:
  - Increments only in RUNNING.
  - Holds its value in STOPPED, so a pause keeps the partial second.
  - tick = RUNNING && prescaler == TICK_DIV-1; prescaler -> 0 on tick.
- Count on tick:
  - ones < 9: ones+1.
  - ones == 9: ones=0; tens = (tens == 5) ? 0 : tens+1.
  - 59 -> 00 registers wrap=1 for exactly one cycle, aligned with the 00 value.
  - No carry-out beyond tens.
- clear (synchronised level high):
  - ones=0, tens=0, prescaler=0, wrap=0.
  - FSM state is unchanged: clear while running keeps running from 00.
  - clear beats a coincident tick.
  - clear together with edge: both apply (counts zeroed and state toggled).
- Display refresh:
  - Free-running counter 0..REFRESH_DIV-1, independent of FSM and clear.
  - At terminal count, enable inverts.
  - an is registered together with enable; never both low, never both high.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- stopwatch_pkg:
  - typedef enum logic {STOPPED, RUNNING} sw_state_t.
  - localparams ONES_MAX=9, TENS_MAX=5.
  - localparam AN_ONES=2'b10, AN_TENS=2'b01.
- One sub-module, sync_edge: 2-flop synchroniser plus rising-edge detector.
  - Ports: clk, reset, d_async, level, rise.
  - Instantiated twice; clear uses level, start_stop uses rise.

Test Plan (TICK_DIV=4, REFRESH_DIV=2):
1. Reset:
   - Stimulus: reset high 2 cycles, then low.
   - Response: ones=0, tens=0, running=0, wrap=0, enable=1, an=2'b10; enable/an alternate every 2 cycles afterwards.
2. Start and count:
   - Stimulus: start_stop pulse of 1 cycle width.
   - Response: running=1 on the 3rd edge; ones increments every 4 cycles: 1, 2, …, 9, then 0 with tens=1.
3. Rollover:
   - Stimulus: run to 59, then one more tick.
   - Response: ones=0, tens=0, wrap=1 for exactly 1 cycle; counting continues.
4. Pause/resume:
   - Stimulus: stop 2 cycles after a tick, hold 20 cycles, restart.
   - Response: count frozen while stopped; next tick arrives 2 cycles after running re-asserts (prescaler retained).
5. Clear while running:
   - Stimulus: assert clear at count 37 for 3 cycles.
   - Response: counts 00, running stays 1; first tick after release is 4 cycles after clear deasserts internally.
6. Simultaneous and mid-operation:
   - Stimulus A: clear and start_stop raised in the same cycle while STOPPED at 12.
   - Response A: counts 00, running=1.
   - Stimulus B: reset mid-run at 45.
   - Response B: all outputs return to reset values on the next edge.
